// File: rtl/gol_pkg.sv
// Shared Game of Life board geometry and LED scanner state encoding.
package gol_pkg;

  localparam int GOL_ROWS  = 8;
  localparam int GOL_COLS  = 8;
  localparam int GOL_CELLS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

endpackage

// File: rtl/tick_counter.sv
// Up-counter from 0 to N-1 with synchronous clear, count enable and terminal flag.
module tick_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_r;

  assign terminal = (count_r == LAST);

  // Count while enabled; restart from zero after the terminal value or on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      if (terminal) begin
        count_r <= {W{1'b0}};
      end else begin
        count_r <= count_r + W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanned 8x8 LED driver for the Game of Life board; shows a shadow copy
// of the board and paces the game with a gen_step pulse every N frames.
module led_matrix_scanner
  import gol_pkg::*;
#(
  parameter int DWELL_CYCLES   = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int FRAMES_PER_GEN = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [GOL_CELLS-1:0] board_in,
  output logic [GOL_ROWS-1:0]  row_sel,
  output logic [GOL_COLS-1:0]  col_data,
  output logic                 gen_step,
  output logic                 frame_done
);

  localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_GEN - 1);
  localparam logic [2:0]    LAST_ROW   = 3'd7;

  scan_state_t          state_r;
  logic [2:0]           row_r;
  logic [FW-1:0]        frame_r;
  logic [GOL_CELLS-1:0] shadow_r;

  logic dwell_term_s;
  logic blank_term_s;
  logic in_scan_s;
  logic in_blank_s;
  logic frame_end_s;
  logic gen_due_s;

  assign in_scan_s   = (state_r == SCAN);
  assign in_blank_s  = (state_r == BLANK);
  assign frame_end_s = in_blank_s && blank_term_s && (row_r == LAST_ROW);
  assign gen_due_s   = frame_end_s && (frame_r == FRAME_LAST);

  tick_counter #(.N(DWELL_CYCLES)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_scan_s),
    .en       (in_scan_s),
    .terminal (dwell_term_s)
  );

  tick_counter #(.N(BLANK_CYCLES)) u_blank (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_blank_s),
    .en       (in_blank_s),
    .terminal (blank_term_s)
  );

  // Output decode uses only registered state so board_in never reaches the LEDs.
  always_comb begin
    row_sel    = {GOL_ROWS{1'b0}};
    col_data   = {GOL_COLS{1'b0}};
    frame_done = frame_end_s;
    gen_step   = gen_due_s;
    if (in_scan_s) begin
      row_sel  = 8'h01 << row_r;
      col_data = shadow_r[{row_r, 3'b000} +: 8];
    end else begin
      row_sel  = {GOL_ROWS{1'b0}};
      col_data = {GOL_COLS{1'b0}};
    end
  end

  // Scan sequencing, frame pacing and shadow capture at generation boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      row_r    <= 3'd0;
      frame_r  <= {FW{1'b0}};
      shadow_r <= {GOL_CELLS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (enable) begin
            shadow_r <= board_in;
            row_r    <= 3'd0;
            frame_r  <= {FW{1'b0}};
            state_r  <= SCAN;
          end
        end
        SCAN: begin
          if (dwell_term_s) begin
            state_r <= BLANK;
          end
        end
        BLANK: begin
          if (blank_term_s) begin
            if (row_r != LAST_ROW) begin
              row_r   <= row_r + 3'd1;
              state_r <= SCAN;
            end else begin
              // A pending generation step fires even when the scan is stopping.
              if (gen_due_s) begin
                shadow_r <= board_in;
                frame_r  <= {FW{1'b0}};
              end else if (enable) begin
                frame_r <= frame_r + FW'(1);
              end else begin
                frame_r <= frame_r;
              end
              row_r   <= 3'd0;
              state_r <= enable ? SCAN : IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench: expected per-cycle LED outputs are queued as stimulus is applied.
module tb_led_matrix_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, enable_a, gen_step_a, frame_done_a;
  logic [63:0] board_a;
  logic [7:0]  row_sel_a, col_data_a;

  logic        reset_b, enable_b, gen_step_b, frame_done_b;
  logic [63:0] board_b;
  logic [7:0]  row_sel_b, col_data_b;

  logic [17:0] exp_q[$];
  logic [17:0] expb_q[$];
  int errors = 0;
  int checks = 0;

  localparam logic [63:0] DIAG = 64'h8040_2010_0804_0201;
  localparam logic [63:0] PATX = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] B0   = 64'hF00F_1234_8001_7E81;
  localparam logic [63:0] B1   = 64'h1122_3344_5566_7788;

  led_matrix_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .FRAMES_PER_GEN(2)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .board_in(board_a),
    .row_sel(row_sel_a), .col_data(col_data_a), .gen_step(gen_step_a), .frame_done(frame_done_a)
  );

  led_matrix_scanner #(.DWELL_CYCLES(1), .BLANK_CYCLES(1), .FRAMES_PER_GEN(1)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .board_in(board_b),
    .row_sel(row_sel_b), .col_data(col_data_b), .gen_step(gen_step_b), .frame_done(frame_done_b)
  );

  task automatic check_vec(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One frame for the 4/2 configuration: 4 lit cycles then 2 blank cycles per row.
  task automatic push_frame(input logic [63:0] brd, input logic gen);
    for (int r = 0; r < 8; r++) begin
      logic [7:0] rs;
      logic       last;
      rs = 8'h01 << r;
      for (int d = 0; d < 4; d++) exp_q.push_back({rs, brd[8*r +: 8], 1'b0, 1'b0});
      for (int b = 0; b < 2; b++) begin
        last = (r == 7) && (b == 1);
        exp_q.push_back({8'h00, 8'h00, last, last & gen});
      end
    end
  endtask

  task automatic run_a(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: observed=no expectation expected=queued entry", tag);
      end else begin
        check_vec(tag, {row_sel_a, col_data_a, frame_done_a, gen_step_a}, exp_q.pop_front());
      end
    end
  endtask

  task automatic check_zero_a(input string tag);
    check_vec(tag, {row_sel_a, col_data_a, frame_done_a, gen_step_a}, 18'h0);
  endtask

  initial begin
    reset_a = 1'b1; enable_a = 1'b1; board_a = 64'hFFFF_FFFF_FFFF_FFFF;
    reset_b = 1'b1; enable_b = 1'b1; board_b = 64'hFFFF_FFFF_FFFF_FFFF;

    repeat (3) begin
      @(negedge clk);
      check_zero_a("reset_hold");
    end

    reset_a = 1'b0;
    board_a = DIAG;
    push_frame(DIAG, 1'b0);
    run_a("frame0_head", 10);
    board_a = 64'h0;
    run_a("frame0_tail", 38);

    push_frame(DIAG, 1'b1);
    run_a("frame1_head", 20);
    enable_a = 1'b0;
    run_a("frame1_tail", 28);

    repeat (3) begin
      @(negedge clk);
      check_zero_a("idle");
    end

    enable_a = 1'b1;
    push_frame(64'h0, 1'b0);
    run_a("frame2_head", 11);
    board_a = 64'hA5A5_A5A5_A5A5_A5A5;
    run_a("frame2_row5", 20);

    #1 reset_a = 1'b1;
    #1 check_zero_a("async_reset");
    exp_q.delete();
    @(negedge clk);
    check_zero_a("reset_mid");
    reset_a = 1'b0;
    board_a = PATX;
    push_frame(PATX, 1'b0);
    push_frame(PATX, 1'b1);
    run_a("restart", 96);

    // Minimal-timing instance: one lit and one blank cycle per row, one frame per generation.
    for (int i = 0; i < 48; i++) begin
      int f, k, r;
      logic [63:0] brd;
      logic [7:0]  rs;
      f = i / 16; k = i % 16; r = k / 2;
      brd = (f < 2) ? B0 : B1;
      rs = 8'h01 << r;
      if (k % 2 == 0) expb_q.push_back({rs, brd[8*r +: 8], 1'b0, 1'b0});
      else expb_q.push_back({8'h00, 8'h00, k == 15, k == 15});
    end
    reset_b = 1'b0;
    board_b = B0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      check_vec("fast_scan", {row_sel_b, col_data_b, frame_done_b, gen_step_b}, expb_q.pop_front());
      checks++;
      assert ($countones(row_sel_b) <= 1) else begin
        errors++;
        $error("FAIL onehot_b: observed=%h expected=at most one bit set", row_sel_b);
      end
      if (i == 20) board_b = B1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
